// File: rtl/iobus_uart_tx_pkg.sv
// Shared constants and types for the OTTER IOBUS UART transmitter.
// Address map, status layout and FSM state encoding.
package otter_uart_pkg;

  localparam logic [31:0] UART_TX_DATA_ADDR = 32'h1100_E000;
  localparam logic [31:0] UART_STATUS_ADDR  = 32'h1100_E004;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/iobus_uart_tx_if.sv
// IOBUS slice seen by the UART: address, write data, strobe, read data.
// The MCU side drives the bus; the UART returns rd_data.
interface iobus_uart_tx_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] rd_data;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  rd_data
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output rd_data
  );

endinterface

// File: rtl/iobus_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 64) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two in 2..64");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !RESET) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// Bytes written to the data address are queued and shifted out LSB first.
module iobus_uart_tx
  import otter_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  iobus_uart_tx_if.slave   bus,
  output logic             tx,
  output logic             tx_empty_intr
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  if (DIV < 4) begin : g_bad_div
    $error("iobus_uart_tx: baud divisor must be at least 4");
  end

  uart_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic           intr_q, intr_d;

  logic           wr_data, wr_stat;
  logic           fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [FAW:0]   fifo_count;
  logic           bit_end;
  logic [31:0]    stat;
  logic [23:0]    unused_wdata;

  assign unused_wdata = bus.IOBUS_OUT[31:8];

  always_comb begin
    wr_data = 1'b0;
    wr_stat = 1'b0;
    if (bus.IOBUS_WR) begin
      unique case (bus.IOBUS_ADDR)
        UART_TX_DATA_ADDR: wr_data = 1'b1;
        UART_STATUS_ADDR:  wr_stat = 1'b1;
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (bus.IOBUS_OUT[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    stat = '0;
    stat[ST_FULL]  = fifo_full;
    stat[ST_EMPTY] = fifo_empty;
    stat[ST_BUSY]  = (state_q != IDLE);
    stat[ST_OVF]   = ovf_q;
    stat[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
  end

  assign bus.rd_data =
    (bus.IOBUS_ADDR == UART_STATUS_ADDR) ? stat : 32'h0;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          idx_d    = '0;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push that lands on a full FIFO survives only if the FSM pops this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_stat) ovf_d = 1'b0;
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
    intr_d = fifo_empty && (state_q == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      intr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      intr_q  <= intr_d;
    end
  end

  assign tx            = tx_q;
  assign tx_empty_intr = intr_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed bench for iobus_uart_tx at 50 MHz / 115200 baud (DIV = 434).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_iobus_uart_tx;
  import otter_uart_pkg::*;

  localparam int DIV = 434;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic intr;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  iobus_uart_tx_if bus ();

  iobus_uart_tx #(
    .CLK_HZ     (50_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (8)
  ) dut (
    .CLK           (clk),
    .RESET         (rst),
    .bus           (bus.slave),
    .tx            (tx),
    .tx_empty_intr (intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    @(negedge clk);
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.IOBUS_ADDR = UART_STATUS_ADDR;
    #1;
    v = bus.rd_data;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bench-side receiver: finds the start bit, then samples mid-bit.
  task automatic rx_frame(output logic [7:0] b, output int t0,
                          output bit ok);
    ok = 1'b0;
    b  = '0;
    t0 = 0;
    for (int i = 0; i < 20 * DIV && !ok; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        t0 = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) begin
      tick(DIV / 2);
      if (tx !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick(DIV);
        b[k] = tx;
      end
      tick(DIV);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    rst = 1'b1;
    bus.IOBUS_ADDR = UART_TX_DATA_ADDR;
    bus.IOBUS_OUT  = 32'h0000_00AA;
    bus.IOBUS_WR   = 1'b1;
    @(negedge clk);
    bus.IOBUS_WR = 1'b0;
    rst = 1'b0;
    n_chk++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx);
    else n_pass++;
    n_chk++;
    if (intr !== 1'b1) $display("FAIL reset_intr got %b want 1", intr);
    else n_pass++;
    read_status(s);
    n_chk++;
    if (s !== 32'h2) $display("FAIL reset_status got %h want 2", s);
    else n_pass++;
    tick(3);
    read_status(s);
    n_chk++;
    if (s !== 32'h2 || tx !== 1'b1)
      $display("FAIL reset_wr_ignored got %h/%b want 2/1", s, tx);
    else n_pass++;
  endtask

  task automatic test_read_decode();
    logic [31:0] s;
    read_status(s);
    n_chk++;
    if (s !== 32'h0000_0002)
      $display("FAIL rd_status got %h want 00000002", s);
    else n_pass++;
    bus.IOBUS_ADDR = 32'h1100_8000;
    #1;
    n_chk++;
    if (bus.rd_data !== 32'h0)
      $display("FAIL rd_other got %h want 0", bus.rd_data);
    else n_pass++;
    bus.IOBUS_ADDR = UART_TX_DATA_ADDR;
    #1;
    n_chk++;
    if (bus.rd_data !== 32'h0)
      $display("FAIL rd_data_addr got %h want 0", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] s;
    logic [7:0]  exp_b = 8'h55;
    logic [7:0]  got;
    bit          bits_ok = 1'b1;
    bus_write(UART_TX_DATA_ADDR, 32'h0000_0055);
    read_status(s);
    n_chk++;
    if (tx !== 1'b1 || s !== 32'h0000_0100)
      $display("FAIL single_edgeN got %b/%h want 1/00000100", tx, s);
    else n_pass++;
    tick(1);
    read_status(s);
    n_chk++;
    if (tx !== 1'b0 || intr !== 1'b0 || s !== 32'h6)
      $display("FAIL single_start got %b/%b/%h want 0/0/6", tx, intr, s);
    else n_pass++;
    tick(DIV - 1);
    n_chk++;
    if (tx !== 1'b0) $display("FAIL single_start_end got %b want 0", tx);
    else n_pass++;
    tick(1);
    n_chk++;
    if (tx !== 1'b1) $display("FAIL single_bit0_edge got %b want 1", tx);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick(DIV / 2);
      got[k] = tx;
      if (tx !== exp_b[k]) bits_ok = 1'b0;
      tick(DIV - DIV / 2);
    end
    n_chk++;
    if (!bits_ok) $display("FAIL single_bits got %h want 55", got);
    else n_pass++;
    n_chk++;
    if (tx !== 1'b1) $display("FAIL single_stop got %b want 1", tx);
    else n_pass++;
    tick(DIV);
    read_status(s);
    n_chk++;
    if (intr !== 1'b0 || s !== 32'h2)
      $display("FAIL single_idle got %b/%h want 0/2", intr, s);
    else n_pass++;
    tick(1);
    n_chk++;
    if (intr !== 1'b1) $display("FAIL single_intr got %b want 1", intr);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    logic [7:0]  a, b, c;
    int          c0, ta, tb_, tc;
    bit          oka, okb, okc;
    bus_write(UART_TX_DATA_ADDR, 32'h41);
    c0 = cyc;
    bus_write(UART_TX_DATA_ADDR, 32'h42);
    bus_write(UART_TX_DATA_ADDR, 32'h43);
    read_status(s);
    n_chk++;
    if (s !== 32'h0000_0204)
      $display("FAIL b2b_count got %h want 00000204", s);
    else n_pass++;
    rx_frame(a, ta, oka);
    rx_frame(b, tb_, okb);
    rx_frame(c, tc, okc);
    n_chk++;
    if (!(oka && okb && okc) || {a, b, c} !== 24'h414243)
      $display("FAIL b2b_abc got %h want 414243", {a, b, c});
    else n_pass++;
    n_chk++;
    if (tb_ - (c0 + 1) !== 10 * DIV + 1)
      $display("FAIL b2b_gap1 got %0d want %0d", tb_ - c0 - 1, 10 * DIV + 1);
    else n_pass++;
    n_chk++;
    if (tc - tb_ !== 10 * DIV + 1)
      $display("FAIL b2b_gap2 got %0d want %0d", tc - tb_, 10 * DIV + 1);
    else n_pass++;
    tick(DIV);
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    pulse_reset();
    bus_write(UART_TX_DATA_ADDR, 32'h10);
    tick(3);
    for (int i = 0; i < 9; i++) bus_write(UART_TX_DATA_ADDR, 32'h11 + i);
    read_status(s);
    n_chk++;
    if (s !== 32'h0000_080D)
      $display("FAIL ovf_set got %h want 0000080d", s);
    else n_pass++;
    bus_write(UART_STATUS_ADDR, 32'hFFFF_FFFF);
    read_status(s);
    n_chk++;
    if (s !== 32'h0000_0805)
      $display("FAIL ovf_clear got %h want 00000805", s);
    else n_pass++;
    pulse_reset();
    read_status(s);
    n_chk++;
    if (s !== 32'h2 || tx !== 1'b1)
      $display("FAIL ovf_flush got %h/%b want 2/1", s, tx);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [31:0] s;
    logic [7:0]  b;
    int          c0, t0;
    bit          ok, all_ok = 1'b1;
    logic [71:0] got = '0;
    pulse_reset();
    bus_write(UART_TX_DATA_ADDR, 32'h30);
    c0 = cyc;
    tick(3);
    for (int i = 0; i < 8; i++) bus_write(UART_TX_DATA_ADDR, 32'h31 + i);
    for (int i = 0; i < 20 * DIV && cyc < c0 + 1 + 10 * DIV; i++)
      @(negedge clk);
    read_status(s);
    n_chk++;
    if (s !== 32'h0000_0801 || tx !== 1'b1)
      $display("FAIL fp_pre got %h/%b want 00000801/1", s, tx);
    else n_pass++;
    bus_write(UART_TX_DATA_ADDR, 32'h39);
    read_status(s);
    n_chk++;
    if (s !== 32'h0000_0805)
      $display("FAIL fp_post got %h want 00000805", s);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      rx_frame(b, t0, ok);
      got = {got[63:0], b};
      if (!ok || b !== 8'(8'h31 + i)) all_ok = 1'b0;
    end
    n_chk++;
    if (!all_ok)
      $display("FAIL fp_order got %h want 313233343536373839", got);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    logic [7:0]  b;
    int          t0;
    bit          ok;
    pulse_reset();
    bus_write(UART_TX_DATA_ADDR, 32'hA5);
    tick(1 + 4 * DIV + DIV / 2);
    read_status(s);
    n_chk++;
    if (tx !== 1'b0 || s !== 32'h6)
      $display("FAIL rm_bit3 got %b/%h want 0/6", tx, s);
    else n_pass++;
    pulse_reset();
    read_status(s);
    n_chk++;
    if (tx !== 1'b1 || s !== 32'h2 || intr !== 1'b1)
      $display("FAIL rm_abort got %b/%h/%b want 1/2/1", tx, s, intr);
    else n_pass++;
    bus_write(UART_TX_DATA_ADDR, 32'h3C);
    rx_frame(b, t0, ok);
    n_chk++;
    if (!ok || b !== 8'h3C)
      $display("FAIL rm_resume got %h ok=%b want 3c", b, ok);
    else n_pass++;
  endtask

  initial begin
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    rst = 1'b1;
    test_reset();
    test_read_decode();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
